dict_loader: RTL and testbench
==============================

Name: dict_loader

Overview:
Writer side of the SD_Sim dictionary memory. It accepts a byte stream of dictionary entries over a valid/ready handshake and packs each byte pair into one 11-bit word. It writes the words into the BRAM port from address DICT_START upward, then writes the entry count to address 0. The cracker reads that count and those words during its dictionary attack.

Parameters:
ADDR_W, 8, BRAM address width
DATA_W, 11, BRAM word width
DICT_START, 1, address of first dictionary entry
DICT_MAX, 10, maximum entries stored; must satisfy DICT_START+DICT_MAX <= 2**ADDR_W

Ports:
clk  in  1  100 MHz system clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse; begins a load session
s_valid  in  1  input byte valid
s_data  in  8  input byte
s_last  in  1  marks final byte of the stream; qualified by s_valid&&s_ready
s_ready  out  1  loader can accept a byte this cycle
ena  out  1  BRAM enable; high only on write cycles
wea  out  1  BRAM write enable; equals ena
addra  out  ADDR_W  BRAM address
dina  out  DATA_W  BRAM write data
busy  out  1  high from accepted start until DONE
done  out  1  held high in DONE until next accepted start or reset
overflow  out  1  set when bytes arrived beyond DICT_MAX entries; cleared by start
count  out  ADDR_W  entries written in current session

Behaviour:
- Reset (async, immediate): state IDLE. Outputs s_ready, ena, wea, busy, done and overflow are 0. addra, dina and count are 0. No partial write completes.
- States: IDLE, RX_LO, RX_HI, WR, DRAIN, HDR, DONE.
- IDLE/DONE, start=1: count<=0, ptr<=DICT_START, overflow<=0, done<=0, go to RX_LO. start in any other state is ignored.
- Byte accept: s_valid&&s_ready. s_ready=1 only in RX_LO, RX_HI and DRAIN.
- RX_LO, accepted byte: lo<=s_data.
  - s_last=0: go to RX_HI.
  - s_last=1: word={3'b0,s_data}, set last flag, go to WR.
- RX_HI, accepted byte: word={s_data[2:0],lo}; s_data[7:3] is discarded. Latch s_last as the last flag, go to WR.
- WR (exactly one cycle): ena=wea=1, addra=ptr, dina=word. The write occurs one cycle after the completing byte is accepted. Next edge: ptr++, count++.
  - Last flag set: go to HDR.
  - Else, count+1==DICT_MAX: go to DRAIN.
  - Else: go to RX_LO.
- DRAIN: accept and discard bytes. On the first accepted byte set overflow=1. Accepted s_last: go to HDR.
- HDR (one cycle): ena=wea=1, addra=0, dina=zero-extended count. Go to DONE.
- DONE: done=1, busy=0, s_ready=0.
- Throughput: 3 cycles per entry minimum. s_ready=0 during WR and HDR.
- Empty stream: not possible, since s_last always accompanies at least one byte.
- Exactly DICT_MAX entries with s_last on the last pair: HDR is entered directly from WR, DRAIN is skipped, overflow stays 0.
- addra and dina hold their last values when ena=0.

Decomposition:
- Package dict_pkg holds:
  - ADDR_W, DATA_W, DICT_START, DICT_MAX defaults, shared with the cracker so the dictionarySize/dictionaryStart values match.
  - COUNT_ADDR=0.
  - The state enumeration encoding.
- One sub-module, word_packer: byte-pair to 11-bit word assembly with the last flag (RX_LO/RX_HI datapath). The FSM stays in dict_loader.

Test Plan:
- Reset mid-RX_HI with a byte pending -> next cycle all outputs 0; no wea pulse; s_ready=0.
- start; bytes 0x41,0x05,0x42,0x00(last) -> writes addr1=0x541, addr2=0x042, addr0=0x002; done=1, count=2, overflow=0.
- start; bytes 0x7F(last) only -> addr1=0x07F, addr0=0x001; done=1.
- start; 12 pairs, last on the 12th -> addr1..10 written, no wea at addr11, addr0=0x00A; overflow=1.
- s_valid toggling every other cycle with a second start pulsed mid-load -> data identical to the gap-free run; start ignored; busy stays 1.
- Hi byte 0xFD with lo 0x10 -> dina=0x510 (upper bits discarded); ena low except the WR/HDR cycles.

Source files
------------

// File: rtl/dict_pkg.sv
// Shared definitions for the SD_Sim dictionary memory.
// The loader writes and the cracker reads this memory, so both import these
// defaults to agree on where the entry count and the entries live.
package dict_pkg;

  localparam int ADDR_W     = 8;   // BRAM address width
  localparam int DATA_W     = 11;  // BRAM word width
  localparam int DICT_START = 1;   // address of first dictionary entry
  localparam int DICT_MAX   = 10;  // maximum entries stored
  localparam int COUNT_ADDR = 0;   // address holding the entry count

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RX_LO = 3'd1,
    S_RX_HI = 3'd2,
    S_WR    = 3'd3,
    S_DRAIN = 3'd4,
    S_HDR   = 3'd5,
    S_DONE  = 3'd6
  } state_e;

endpackage

// File: rtl/dict_loader_word_packer.sv
// word_packer: assembles a byte pair into one dictionary word.
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   acc_lo_i    low byte accepted this cycle
//   acc_hi_i    high byte accepted this cycle
//   data_i      incoming byte
//   last_i      incoming byte is the final byte of the stream
//   word_o      word formed by the byte completing an entry (valid with the
//               accepting cycle, combinational)
//   last_o      last flag of the most recently completed entry
module word_packer
  import dict_pkg::*;
#(
  parameter int DATA_W = dict_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              acc_lo_i,
  input  logic              acc_hi_i,
  input  logic [7:0]        data_i,
  input  logic              last_i,
  output logic [DATA_W-1:0] word_o,
  output logic              last_o
);

  localparam int HI_W = DATA_W - 8;

  logic [7:0] lo_q;
  logic       last_q;

  // Low byte is pure data, so it carries no reset.
  always_ff @(posedge clk) begin
    if (acc_lo_i) lo_q <= data_i;
  end

  // A lone low byte can only complete an entry when it is the last byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    last_q <= 1'b0;
    else if (acc_hi_i)            last_q <= last_i;
    else if (acc_lo_i && last_i)  last_q <= 1'b1;
  end

  // High byte contributes only its low HI_W bits; the rest is dropped.
  always_comb begin
    if (acc_hi_i) word_o = {data_i[HI_W-1:0], lo_q};
    else          word_o = {{HI_W{1'b0}}, data_i};
  end

  assign last_o = last_q;

endmodule

// File: rtl/dict_loader.sv
// dict_loader: writer side of the SD_Sim dictionary memory.
// Packs byte pairs from a valid/ready stream into words written from
// DICT_START upward, then writes the entry count to COUNT_ADDR.
// Ports:
//   clk, reset         clock and asynchronous active-high reset
//   start              pulse that begins a session (IDLE/DONE only)
//   s_valid/s_data/s_last/s_ready   byte stream handshake
//   ena, wea, addra, dina           BRAM write port (registered, hold when idle)
//   busy, done, overflow, count     session status
module dict_loader
  import dict_pkg::*;
#(
  parameter int ADDR_W     = dict_pkg::ADDR_W,
  parameter int DATA_W     = dict_pkg::DATA_W,
  parameter int DICT_START = dict_pkg::DICT_START,
  parameter int DICT_MAX   = dict_pkg::DICT_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W-1:0] count
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                ena_q, ena_d;
  logic [ADDR_W-1:0]   addra_q, addra_d;
  logic [DATA_W-1:0]   dina_q, dina_d;

  logic                accept;
  logic                acc_lo, acc_hi;
  logic [DATA_W-1:0]   word;
  logic                last_flag;
  logic [ADDR_W-1:0]   count_inc;

  assign s_ready = (state_q == S_RX_LO) || (state_q == S_RX_HI) ||
                   (state_q == S_DRAIN);
  assign accept  = s_valid && s_ready;
  assign acc_lo  = accept && (state_q == S_RX_LO);
  assign acc_hi  = accept && (state_q == S_RX_HI);
  assign count_inc = count_q + 1'b1;

  word_packer #(.DATA_W(DATA_W)) u_packer (
    .clk      (clk),
    .reset    (reset),
    .acc_lo_i (acc_lo),
    .acc_hi_i (acc_hi),
    .data_i   (s_data),
    .last_i   (s_last),
    .word_o   (word),
    .last_o   (last_flag)
  );

  // The BRAM port is registered one step ahead: ena_d/addra_d/dina_d are
  // loaded on the edge that enters WR or HDR, so the port is live exactly
  // during those states and holds its values otherwise.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    ena_d   = 1'b0;
    addra_d = addra_q;
    dina_d  = dina_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          count_d = '0;
          ptr_d   = ADDR_W'(DICT_START);
          ovf_d   = 1'b0;
          state_d = S_RX_LO;
        end
      end
      S_RX_LO, S_RX_HI: begin
        if (accept && (s_last || state_q == S_RX_HI)) begin
          state_d = S_WR;
          ena_d   = 1'b1;
          addra_d = ptr_q;
          dina_d  = word;
        end else if (accept) begin
          state_d = S_RX_HI;
        end
      end
      S_WR: begin
        ptr_d   = ptr_q + 1'b1;
        count_d = count_inc;
        if (last_flag) begin
          state_d = S_HDR;
          ena_d   = 1'b1;
          addra_d = ADDR_W'(COUNT_ADDR);
          dina_d  = DATA_W'(count_inc);
        end else if (count_inc == ADDR_W'(DICT_MAX)) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_RX_LO;
        end
      end
      S_DRAIN: begin
        if (accept) begin
          ovf_d = 1'b1;
          if (s_last) begin
            state_d = S_HDR;
            ena_d   = 1'b1;
            addra_d = ADDR_W'(COUNT_ADDR);
            dina_d  = DATA_W'(count_q);
          end
        end
      end
      S_HDR:   state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      ena_q   <= 1'b0;
      addra_q <= '0;
      dina_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      ena_q   <= ena_d;
      addra_q <= addra_d;
      dina_q  <= dina_d;
    end
  end

  assign ena      = ena_q;
  assign wea      = ena_q;
  assign addra    = addra_q;
  assign dina     = dina_q;
  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done     = (state_q == S_DONE);
  assign overflow = ovf_q;
  assign count    = count_q;

endmodule

// File: tb/tb_dict_loader.sv
module tb_dict_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_last;
  logic        s_ready;
  logic        ena, wea;
  logic [7:0]  addra;
  logic [10:0] dina;
  logic        busy, done, overflow;
  logic [7:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  qa[$];
  logic [10:0] qd[$];

  always #5 clk = ~clk;

  dict_loader dut (
    .clk(clk), .reset(reset), .start(start),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .busy(busy), .done(done), .overflow(overflow), .count(count)
  );

  typedef struct packed {
    int               nb;
    logic [23:0][7:0] b;
    bit               gap;
    bit               mid_start;
    int               nw;
    logic [11:0][7:0] wa;
    logic [11:0][10:0] wd;
    logic [7:0]       cnt;
    bit               ovf;
  } vec_t;

  vec_t vecs[7];

  // Record every write cycle of the BRAM port.
  always @(negedge clk) begin
    if (wea !== ena) begin
      n_bad++;
      $display("FAIL wea_eq_ena: wea=%b ena=%b", wea, ena);
    end
    if (ena === 1'b1) begin
      qa.push_back(addra);
      qd.push_back(dina);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input bit gap);
    int guard = 0;
    if (gap) begin
      @(negedge clk); s_valid = 1'b0;
    end
    @(negedge clk);
    s_valid = 1'b1; s_data = b; s_last = last;
    while (!s_ready && guard < 50) begin
      @(negedge clk); guard++;
    end
    if (guard >= 50) chk("s_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_done();
    int guard = 0;
    @(negedge clk);
    while (!done && guard < 40) begin
      @(negedge clk); guard++;
    end
    if (guard >= 40) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    v = vecs[k];
    qa.delete(); qd.delete();
    pulse_start();
    chk($sformatf("v%0d_busy_after_start", k), busy, 1'b1);
    chk($sformatf("v%0d_done_cleared", k), done, 1'b0);
    for (int i = 0; i < v.nb; i++) begin
      if (v.mid_start && i == 2) begin
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk($sformatf("v%0d_busy_mid_start", k), busy, 1'b1);
      end
      send_byte(v.b[i], (i == v.nb - 1), v.gap);
    end
    wait_done();
    chk($sformatf("v%0d_done", k), done, 1'b1);
    chk($sformatf("v%0d_busy_low", k), busy, 1'b0);
    chk($sformatf("v%0d_s_ready_low", k), s_ready, 1'b0);
    chk($sformatf("v%0d_count", k), count, v.cnt);
    chk($sformatf("v%0d_overflow", k), overflow, v.ovf);
    chk($sformatf("v%0d_nwrites", k), qa.size(), v.nw);
    for (int j = 0; j < v.nw && j < qa.size(); j++) begin
      chk($sformatf("v%0d_w%0d_addr", k, j), qa[j], v.wa[j]);
      chk($sformatf("v%0d_w%0d_data", k, j), qd[j], v.wd[j]);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;

    for (int k = 0; k < 7; k++) vecs[k] = '0;
    // 0x41,0x05,0x42,0x00(last)
    vecs[0].nb = 4; vecs[0].b[0] = 8'h41; vecs[0].b[1] = 8'h05;
    vecs[0].b[2] = 8'h42; vecs[0].b[3] = 8'h00;
    vecs[0].nw = 3;
    vecs[0].wa[0] = 8'd1; vecs[0].wd[0] = 11'h541;
    vecs[0].wa[1] = 8'd2; vecs[0].wd[1] = 11'h042;
    vecs[0].wa[2] = 8'd0; vecs[0].wd[2] = 11'h002;
    vecs[0].cnt = 8'd2; vecs[0].ovf = 1'b0;
    // single byte 0x7F(last)
    vecs[1].nb = 1; vecs[1].b[0] = 8'h7F; vecs[1].nw = 2;
    vecs[1].wa[0] = 8'd1; vecs[1].wd[0] = 11'h07F;
    vecs[1].wa[1] = 8'd0; vecs[1].wd[1] = 11'h001;
    vecs[1].cnt = 8'd1;
    // 12 pairs, lo=0x20+i hi=i: entries 11 and 12 are drained
    vecs[2].nb = 24; vecs[2].nw = 11; vecs[2].cnt = 8'd10; vecs[2].ovf = 1'b1;
    for (int i = 0; i < 12; i++) begin
      vecs[2].b[2*i]   = 8'(8'h20 + i);
      vecs[2].b[2*i+1] = 8'(i);
    end
    for (int i = 0; i < 10; i++) begin
      vecs[2].wa[i] = 8'(i + 1);
      vecs[2].wd[i] = 11'(((i % 8) << 8) | (8'h20 + i));
    end
    vecs[2].wa[10] = 8'd0; vecs[2].wd[10] = 11'h00A;
    // same as vector 0 with gaps and a stray start mid-load
    vecs[3] = vecs[0]; vecs[3].gap = 1'b1; vecs[3].mid_start = 1'b1;
    // lo 0x10, hi 0xFD(last): upper hi bits dropped
    vecs[4].nb = 2; vecs[4].b[0] = 8'h10; vecs[4].b[1] = 8'hFD; vecs[4].nw = 2;
    vecs[4].wa[0] = 8'd1; vecs[4].wd[0] = 11'h510;
    vecs[4].wa[1] = 8'd0; vecs[4].wd[1] = 11'h001;
    vecs[4].cnt = 8'd1;
    // exactly 10 pairs: no drain, no overflow
    vecs[5] = vecs[2]; vecs[5].nb = 20; vecs[5].ovf = 1'b0;
    // odd length: 0x01,0x02,0x03(last)
    vecs[6].nb = 3; vecs[6].b[0] = 8'h01; vecs[6].b[1] = 8'h02; vecs[6].b[2] = 8'h03;
    vecs[6].nw = 3;
    vecs[6].wa[0] = 8'd1; vecs[6].wd[0] = 11'h201;
    vecs[6].wa[1] = 8'd2; vecs[6].wd[1] = 11'h003;
    vecs[6].wa[2] = 8'd0; vecs[6].wd[2] = 11'h002;
    vecs[6].cnt = 8'd2;

    repeat (3) @(negedge clk);
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_ena", ena, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_count", count, 8'd0);
    reset = 1'b0;
    @(negedge clk);
    qa.delete(); qd.delete();

    for (int k = 0; k < 7; k++) run_vec(k);

    // Overflow must clear on the next start.
    pulse_start();
    chk("ovf_cleared_by_start", overflow, 1'b0);

    // Asynchronous reset while a high byte is pending in RX_HI.
    qa.delete(); qd.delete();
    send_byte(8'h33, 1'b0, 1'b0);
    s_valid = 1'b1; s_data = 8'h44; s_last = 1'b0;
    chk("pre_rst_in_rx_hi", s_ready, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("arst_s_ready", s_ready, 1'b0);
    chk("arst_ena", ena, 1'b0);
    chk("arst_wea", wea, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_overflow", overflow, 1'b0);
    chk("arst_addra", addra, 8'd0);
    chk("arst_dina", dina, 11'd0);
    chk("arst_count", count, 8'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0; s_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst_no_write", qa.size(), 32'd0);
    chk("arst_idle_busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
